// File: rtl/sda_kernel_ctrl_reg_multi_pkg.sv
// Shared definitions for the multi-channel ap_ctrl register block:
// register word offsets, CTRL/ISR bit positions and the channel FSM encoding.
package sda_kernel_ctrl_reg_multi_pkg;

    // Word index (reg_addr[4:2]) of each register.
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_GIE       = 3'd1;
    localparam logic [2:0] REG_IER       = 3'd2;
    localparam logic [2:0] REG_ISR       = 3'd3;
    localparam logic [2:0] REG_CHAN_DONE = 3'd4;
    localparam logic [2:0] REG_CYCLES    = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_AUTO  = 7;

    localparam int ISR_DONE  = 0;
    localparam int ISR_READY = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GO_HI   = 3'd1,
        ST_GO_LO   = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE_HI = 3'd4,
        ST_FIN     = 3'd5
    } chan_state_e;

endpackage

// File: rtl/sda_kernel_ctrl_reg_multi_if.sv
// Register bus between the wrapper (master) and the kernel control block (slave).
interface sda_kernel_ctrl_reg_multi_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  reg_req;
    logic                  reg_ack;
    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [31:0]           reg_wdata;
    logic [3:0]            reg_wstrb;
    logic [31:0]           reg_rdata;

    modport master (
        output reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
        input  reg_ack, reg_rdata
    );

    modport slave (
        input  reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
        output reg_ack, reg_rdata
    );
endinterface

// File: rtl/sda_kernel_ctrl_reg_multi_chan_hs.sv
// One channel's four-phase go/done handshake with the action core.
// in_run stays high from RUN until the channel is released from FIN.
module sda_kernel_ctrl_reg_multi_chan_hs
    import sda_kernel_ctrl_reg_multi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic release_run,
    input  logic restart,
    input  logic go_a,
    input  logic done_r,
    output logic go_r,
    output logic done_a,
    output logic in_run,
    output logic at_fin
);

    chan_state_e state_q, state_d;

    // NOTE: flops use <= so every register samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        go_r    = 1'b0;
        done_a  = 1'b0;
        in_run  = 1'b0;
        at_fin  = 1'b0;
        case (state_q)
            ST_IDLE:    if (launch) state_d = ST_GO_HI;
            ST_GO_HI: begin
                go_r = 1'b1;
                if (go_a) state_d = ST_GO_LO;
            end
            ST_GO_LO:   if (!go_a) state_d = ST_RUN;
            ST_RUN: begin
                in_run = 1'b1;
                if (done_r) state_d = ST_DONE_HI;
            end
            ST_DONE_HI: begin
                in_run = 1'b1;
                done_a = 1'b1;
                if (!done_r) state_d = ST_FIN;
            end
            ST_FIN: begin
                in_run = 1'b1;
                at_fin = 1'b1;
                if (release_run) state_d = restart ? ST_GO_HI : ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/sda_kernel_ctrl_reg_multi.sv
// ap_ctrl register file, bus decode, run-cycle counter and interrupt for
// NUM_CHANNELS go/done action channels.
module sda_kernel_ctrl_reg_multi
    import sda_kernel_ctrl_reg_multi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    sda_kernel_ctrl_reg_multi_if.slave bus,
    output logic [NUM_CHANNELS-1:0] go_r,
    input  logic [NUM_CHANNELS-1:0] go_a,
    input  logic [NUM_CHANNELS-1:0] done_r,
    output logic [NUM_CHANNELS-1:0] done_a,
    output logic                    interrupt
);

    logic                    served_q, served_d, ack_q, ack_d;
    logic [31:0]             rdata_q, rdata_d, read_mux;
    logic                    ap_start_q, ap_start_d, ap_done_q, ap_done_d;
    logic                    ap_idle_q, ap_idle_d, auto_restart_q, auto_restart_d;
    logic                    gie_q, gie_d, all_run_q, all_run_d;
    logic [1:0]              ier_q, ier_d, isr_q, isr_d;
    logic [NUM_CHANNELS-1:0] chan_done_q, chan_done_d, in_run, at_fin;
    logic [COUNT_WIDTH-1:0]  cycles_q, cycles_d;
    logic [2:0]              word;
    logic                    serve, wr, rd, launch, all_run, all_fin, ready_pulse, restart_now;
    logic                    unused_ok;

    assign word        = bus.reg_addr[4:2];
    // A held request is served once; it must drop before the next access.
    assign serve       = bus.reg_req && !served_q && (bus.reg_addr[ADDR_WIDTH-1:5] == '0);
    assign wr          = serve && bus.reg_write_en && bus.reg_wstrb[0];
    assign rd          = serve && !bus.reg_write_en;
    assign launch      = wr && (word == REG_CTRL) && bus.reg_wdata[CTRL_START] && ap_idle_q;
    assign all_run     = &in_run;
    assign all_fin     = &at_fin;
    assign ready_pulse = all_run && !all_run_q;
    assign restart_now = all_fin && auto_restart_q;
    assign unused_ok   = ^{bus.reg_wstrb, bus.reg_addr, bus.reg_wdata};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        sda_kernel_ctrl_reg_multi_chan_hs u_chan (
            .clk         (clk),
            .reset       (reset),
            .launch      (launch),
            .release_run (all_fin),
            .restart     (auto_restart_q),
            .go_a        (go_a[i]),
            .done_r      (done_r[i]),
            .go_r        (go_r[i]),
            .done_a      (done_a[i]),
            .in_run      (in_run[i]),
            .at_fin      (at_fin[i])
        );
    end

    always_comb begin
        read_mux = '0;
        case (word)
            REG_CTRL: begin
                read_mux[CTRL_START] = ap_start_q;
                read_mux[CTRL_DONE]  = ap_done_q;
                read_mux[CTRL_IDLE]  = ap_idle_q;
                read_mux[CTRL_READY] = ready_pulse;
                read_mux[CTRL_AUTO]  = auto_restart_q;
            end
            REG_GIE:       read_mux[0]                = gie_q;
            REG_IER:       read_mux[1:0]              = ier_q;
            REG_ISR:       read_mux[1:0]              = isr_q;
            REG_CHAN_DONE: read_mux[NUM_CHANNELS-1:0] = chan_done_q;
            REG_CYCLES:    read_mux[COUNT_WIDTH-1:0]  = cycles_q;
            default:       read_mux                   = '0;
        endcase
    end

    // Later assignments take priority: hardware sets override bus clears/toggles.
    always_comb begin
        served_d       = bus.reg_req && (served_q || serve);
        ack_d          = serve;
        rdata_d        = rd ? read_mux : '0;
        ap_start_d     = ap_start_q;
        ap_done_d      = ap_done_q;
        ap_idle_d      = ap_idle_q;
        auto_restart_d = auto_restart_q;
        gie_d          = gie_q;
        ier_d          = ier_q;
        isr_d          = isr_q;
        chan_done_d    = chan_done_q | at_fin;
        cycles_d       = cycles_q;
        all_run_d      = all_run;

        if (wr) begin
            case (word)
                REG_CTRL: auto_restart_d = bus.reg_wdata[CTRL_AUTO];
                REG_GIE:  gie_d          = bus.reg_wdata[0];
                REG_IER:  ier_d          = bus.reg_wdata[1:0];
                REG_ISR:  isr_d          = isr_q ^ bus.reg_wdata[1:0];
                default:  ;
            endcase
        end
        if (rd && (word == REG_CTRL)) ap_done_d = 1'b0;
        if (launch) begin
            ap_start_d = 1'b1;
            ap_idle_d  = 1'b0;
        end
        if (ready_pulse) begin
            isr_d[ISR_READY] = 1'b1;
            if (!auto_restart_q) ap_start_d = 1'b0;
        end
        if (all_fin) begin
            ap_done_d       = 1'b1;
            isr_d[ISR_DONE] = 1'b1;
            if (!auto_restart_q) begin
                ap_idle_d  = 1'b1;
                ap_start_d = 1'b0;
            end
        end
        if (launch || restart_now) begin
            chan_done_d = '0;
            cycles_d    = '0;
        end else if (!ap_idle_q && (cycles_q != '1)) begin
            cycles_d = cycles_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served_q       <= 1'b0;
            ack_q          <= 1'b0;
            rdata_q        <= '0;
            ap_start_q     <= 1'b0;
            ap_done_q      <= 1'b0;
            ap_idle_q      <= 1'b1;
            auto_restart_q <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= '0;
            isr_q          <= '0;
            chan_done_q    <= '0;
            cycles_q       <= '0;
            all_run_q      <= 1'b0;
        end else begin
            served_q       <= served_d;
            ack_q          <= ack_d;
            rdata_q        <= rdata_d;
            ap_start_q     <= ap_start_d;
            ap_done_q      <= ap_done_d;
            ap_idle_q      <= ap_idle_d;
            auto_restart_q <= auto_restart_d;
            gie_q          <= gie_d;
            ier_q          <= ier_d;
            isr_q          <= isr_d;
            chan_done_q    <= chan_done_d;
            cycles_q       <= cycles_d;
            all_run_q      <= all_run_d;
        end
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign interrupt     = gie_q & |(ier_q & isr_q);

endmodule
